// File: rtl/ddr3_pll_phase_sequencer_if.sv
// Request channel into the PLL phase sequencer: one N-step phase move on one PLL output counter.
// Handshake: a request transfers on a rising clock edge where req_valid && req_ready; the
// master holds req_ch/req_updn/req_count stable while req_valid is high and not yet accepted.
interface ddr3_pll_phase_sequencer_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [CH_W-1:0]  req_ch;
  logic             req_updn;
  logic [CNT_W-1:0] req_count;

  modport master (output req_valid, req_ch, req_updn, req_count, input req_ready);
  modport slave  (input req_valid, req_ch, req_updn, req_count, output req_ready);
endinterface

// File: rtl/ddr3_pll_phase_sequencer.sv
// PLL dynamic-phase-shift sequencer: turns N-step requests into spaced phase_step pulses,
// waits on phase_done with a timeout, and tracks each counter's phase modulo one period.
module ddr3_pll_phase_sequencer #(
  parameter int NUM_CH        = 4,
  parameter int STEPS_PER_REV = 56,
  parameter int CNT_W         = 8,
  parameter int PULSE_HI      = 2,
  parameter int MIN_GAP       = 4,
  parameter int DONE_TIMEOUT  = 1023,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      CLK_IN,
  input  logic                      RST_IN_N,
  ddr3_pll_phase_sequencer_if.slave req,
  input  logic                      abort,
  output logic                      phase_step,
  output logic                      phase_updn,
  output logic [CH_W-1:0]           phase_cntsel,
  input  logic                      phase_done,
  output logic                      busy,
  output logic                      cmpl,
  output logic                      err_timeout,
  output logic                      err_badch,
  output logic [NUM_CH*CNT_W-1:0]   pos,
  output logic [2:0]                dbg_state
);

  localparam int TMR_MAX = (DONE_TIMEOUT > PULSE_HI) ? DONE_TIMEOUT : PULSE_HI;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_HI - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(MIN_GAP - 1);
  localparam logic [TMR_W-1:0] TO_LAST    = TMR_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] POS_LAST   = CNT_W'(STEPS_PER_REV - 1);
  localparam logic [CH_W:0]    NUM_CH_EXT = (CH_W + 1)'(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_GAP   = 3'd3,
    S_WAIT  = 3'd4,
    S_NEXT  = 3'd5,
    S_ERR   = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t           state;
  logic [CH_W-1:0]  ch_q;
  logic [CNT_W-1:0] remaining;
  logic [TMR_W-1:0] timer;
  logic             abort_q;
  logic [CNT_W-1:0] pos_q [NUM_CH];
  logic             ch_bad;

  assign req.req_ready = (state == S_IDLE);
  assign dbg_state     = state;
  assign ch_bad        = ({1'b0, req.req_ch} >= NUM_CH_EXT);

  always_comb begin
    pos = '0;
    for (int i = 0; i < NUM_CH; i++) pos[i*CNT_W +: CNT_W] = pos_q[i];
  end

  function automatic logic [CNT_W-1:0] step_pos(input logic [CNT_W-1:0] p, input logic up);
    if (up) return (p == POS_LAST) ? '0 : p + 1'b1;
    else    return (p == '0) ? POS_LAST : p - 1'b1;
  endfunction

  always_ff @(posedge CLK_IN or negedge RST_IN_N) begin
    if (!RST_IN_N) begin
      state        <= S_IDLE;
      phase_step   <= 1'b0;
      phase_updn   <= 1'b0;
      phase_cntsel <= '0;
      busy         <= 1'b0;
      cmpl         <= 1'b0;
      err_timeout  <= 1'b0;
      err_badch    <= 1'b0;
      ch_q         <= '0;
      remaining    <= '0;
      timer        <= '0;
      abort_q      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) pos_q[i] <= '0;
    end else begin
      cmpl      <= 1'b0;
      err_badch <= 1'b0;
      // abort only takes effect at the step boundary, so latching it is enough
      if (state != S_IDLE && abort) abort_q <= 1'b1;

      case (state)
        S_IDLE: begin
          if (req.req_valid) begin
            err_timeout <= 1'b0;
            abort_q     <= 1'b0;
            if (ch_bad) begin
              err_badch <= 1'b1;
              cmpl      <= 1'b1;
              state     <= S_DONE;
            end else begin
              ch_q         <= req.req_ch;
              phase_cntsel <= req.req_ch;
              phase_updn   <= req.req_updn;
              remaining    <= req.req_count;
              if (req.req_count == '0) begin
                cmpl  <= 1'b1;
                state <= S_DONE;
              end else begin
                busy  <= 1'b1;
                state <= S_SETUP;
              end
            end
          end
        end

        S_SETUP: begin
          phase_step <= 1'b1;
          timer      <= '0;
          state      <= S_PULSE;
        end

        S_PULSE: begin
          if (timer == PULSE_LAST) begin
            phase_step <= 1'b0;
            timer      <= '0;
            state      <= S_GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // Timer keeps running from GAP entry into WAIT so the timeout spans both.
        S_GAP: begin
          if (timer == GAP_LAST) begin
            if (phase_done)            state <= S_NEXT;
            else if (timer == TO_LAST) state <= S_ERR;
            else begin
              timer <= timer + 1'b1;
              state <= S_WAIT;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_WAIT: begin
          if (phase_done)            state <= S_NEXT;
          else if (timer == TO_LAST) state <= S_ERR;
          else                       timer <= timer + 1'b1;
        end

        S_NEXT: begin
          pos_q[ch_q] <= step_pos(pos_q[ch_q], phase_updn);
          remaining   <= remaining - 1'b1;
          if (remaining == CNT_W'(1) || abort_q || abort) begin
            cmpl  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_SETUP;
          end
        end

        S_ERR: begin
          err_timeout <= 1'b1;
          cmpl        <= 1'b1;
          state       <= S_DONE;
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  a_step_only_in_pulse: assert property (@(posedge CLK_IN) disable iff (!RST_IN_N)
    phase_step == (state == S_PULSE));

  a_sel_stable_while_busy: assert property (@(posedge CLK_IN) disable iff (!RST_IN_N)
    (busy && $past(busy)) |-> ($stable(phase_cntsel) && $stable(phase_updn)));

endmodule
